// File: rtl/itch_event_arbiter.sv
// itch_event_arbiter
//
// Merges decoded order events from two itch_parser instances (feed A = ch0,
// feed B = ch1) into a single stream for the book builder. The parsers cannot
// be stalled, so each channel lands in its own small event FIFO. A round-robin
// scheduler drains both FIFOs through one registered valid/ready output stage,
// and events that arrive while a FIFO is full are dropped and counted.
//
// Ports
//   clkIn, rstNIn        clock, asynchronous active-low reset
//   chAddValidIn[1:0]    per-channel add event pulse
//   chDelValidIn[1:0]    per-channel delete event pulse
//   chExecValidIn[1:0]   per-channel execute event pulse
//   chRefNumIn/chLocateIn/chPriceIn/chSharesIn/chBuySellIn
//                        per-channel event fields, sampled with the pulse
//   evtValidOut/evtReadyIn  output handshake
//   evtTypeOut           01 add, 10 delete, 11 execute
//   evtChanOut           source channel of the presented event
//   evtRefNumOut..evtBuySellOut  event fields, unchanged from the input
//   dropCntOut[1:0]      per-channel saturating overflow drop count
//   protoErrOut[1:0]     per-channel sticky flag for multi-hot valids

module itch_event_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clkIn,
  input  logic                  rstNIn,
  input  logic [1:0]            chAddValidIn,
  input  logic [1:0]            chDelValidIn,
  input  logic [1:0]            chExecValidIn,
  input  logic [1:0][63:0]      chRefNumIn,
  input  logic [1:0][15:0]      chLocateIn,
  input  logic [1:0][31:0]      chPriceIn,
  input  logic [1:0][31:0]      chSharesIn,
  input  logic [1:0]            chBuySellIn,
  output logic                  evtValidOut,
  input  logic                  evtReadyIn,
  output logic [1:0]            evtTypeOut,
  output logic                  evtChanOut,
  output logic [63:0]           evtRefNumOut,
  output logic [15:0]           evtLocateOut,
  output logic [31:0]           evtPriceOut,
  output logic [31:0]           evtSharesOut,
  output logic                  evtBuySellOut,
  output logic [1:0][CNT_W-1:0] dropCntOut,
  output logic [1:0]            protoErrOut
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]  evt_type;
    logic [63:0] ref_num;
    logic [15:0] locate;
    logic [31:0] price;
    logic [31:0] shares;
    logic        buy_sell;
  } evt_t;

  typedef enum logic {
    IDLE     = 1'b0,
    HAVE_EVT = 1'b1
  } state_t;

  // Per-channel FIFO state
  evt_t             fifo_mem_q [2][FIFO_DEPTH];
  evt_t             fifo_mem_d [2][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q   [2];
  logic [PTR_W-1:0] wr_ptr_d   [2];
  logic [PTR_W-1:0] rd_ptr_q   [2];
  logic [PTR_W-1:0] rd_ptr_d   [2];
  logic [OCC_W-1:0] count_q    [2];
  logic [OCC_W-1:0] count_d    [2];

  logic [1:0][CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [1:0]            proto_err_q, proto_err_d;

  // Scheduler / output stage state
  state_t state_q, state_d;
  logic   rr_q, rr_d;
  evt_t   out_evt_q, out_evt_d;
  logic   out_chan_q, out_chan_d;

  // Combinational helpers
  evt_t       push_evt [2];
  logic [1:0] ch_event;
  logic [1:0] multi_hot;
  logic [1:0] fifo_empty;
  logic [1:0] fifo_full;
  logic [1:0] pop;
  logic [1:0] push_accept;
  logic [1:0] drop;
  logic       any_avail;
  logic       load_en;
  logic       do_load;
  logic       serve_ch;

  // Decode the per-channel valids into one event. Add beats delete, delete
  // beats execute when a parser raises more than one valid in a cycle.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      ch_event[ch]  = chAddValidIn[ch] | chDelValidIn[ch] | chExecValidIn[ch];
      multi_hot[ch] = (chAddValidIn[ch] & chDelValidIn[ch]) |
                      (chAddValidIn[ch] & chExecValidIn[ch]) |
                      (chDelValidIn[ch] & chExecValidIn[ch]);
      if (chAddValidIn[ch]) begin
        push_evt[ch].evt_type = 2'b01;
      end else if (chDelValidIn[ch]) begin
        push_evt[ch].evt_type = 2'b10;
      end else begin
        push_evt[ch].evt_type = 2'b11;
      end
      push_evt[ch].ref_num  = chRefNumIn[ch];
      push_evt[ch].locate   = chLocateIn[ch];
      push_evt[ch].price    = chPriceIn[ch];
      push_evt[ch].shares   = chSharesIn[ch];
      push_evt[ch].buy_sell = chBuySellIn[ch];
    end
  end

  // Scheduler decision. The output register reloads when it is empty or
  // being consumed; the RR channel is preferred if it has anything queued.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      fifo_empty[ch] = (count_q[ch] == '0);
      fifo_full[ch]  = (count_q[ch] == OCC_W'(FIFO_DEPTH));
    end
    any_avail = ~(fifo_empty[0] & fifo_empty[1]);
    load_en   = (state_q == IDLE) | evtReadyIn;
    do_load   = load_en & any_avail;
    serve_ch  = fifo_empty[rr_q] ? ~rr_q : rr_q;
    for (int ch = 0; ch < 2; ch++) begin
      pop[ch] = do_load & (serve_ch == 1'(ch));
    end
  end

  // FIFO bookkeeping. A full FIFO still accepts a push in the cycle it is
  // popped, so a steady-state full queue never drops while draining.
  always_comb begin
    fifo_mem_d  = fifo_mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    drop_cnt_d  = drop_cnt_q;
    proto_err_d = proto_err_q;
    push_accept = '0;
    drop        = '0;
    for (int ch = 0; ch < 2; ch++) begin
      push_accept[ch] = ch_event[ch] & (~fifo_full[ch] | pop[ch]);
      drop[ch]        = ch_event[ch] & fifo_full[ch] & ~pop[ch];
      if (push_accept[ch]) begin
        fifo_mem_d[ch][wr_ptr_q[ch]] = push_evt[ch];
        wr_ptr_d[ch] = wr_ptr_q[ch] + 1'b1;
      end
      if (pop[ch]) begin
        rd_ptr_d[ch] = rd_ptr_q[ch] + 1'b1;
      end
      count_d[ch] = count_q[ch] + OCC_W'(push_accept[ch]) - OCC_W'(pop[ch]);
      if (drop[ch] && (drop_cnt_q[ch] != '1)) begin
        drop_cnt_d[ch] = drop_cnt_q[ch] + 1'b1;
      end
      if (multi_hot[ch]) begin
        proto_err_d[ch] = 1'b1;
      end
    end
  end

  // Output-stage FSM: HAVE_EVT exactly when the output register holds an
  // event, so evtValidOut comes straight from the state register.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    out_evt_d  = out_evt_q;
    out_chan_d = out_chan_q;
    case (state_q)
      IDLE: begin
        if (any_avail) begin
          state_d = HAVE_EVT;
        end
      end
      HAVE_EVT: begin
        if (evtReadyIn && !any_avail) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (do_load) begin
      out_evt_d  = fifo_mem_q[serve_ch][rd_ptr_q[serve_ch]];
      out_chan_d = serve_ch;
      rr_d       = ~serve_ch;
    end
  end

  always_ff @(posedge clkIn or negedge rstNIn) begin
    if (!rstNIn) begin
      fifo_mem_q  <= '{default: '0};
      wr_ptr_q    <= '{default: '0};
      rd_ptr_q    <= '{default: '0};
      count_q     <= '{default: '0};
      drop_cnt_q  <= '0;
      proto_err_q <= '0;
      state_q     <= IDLE;
      rr_q        <= 1'b0;
      out_evt_q   <= '0;
      out_chan_q  <= 1'b0;
    end else begin
      fifo_mem_q  <= fifo_mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      drop_cnt_q  <= drop_cnt_d;
      proto_err_q <= proto_err_d;
      state_q     <= state_d;
      rr_q        <= rr_d;
      out_evt_q   <= out_evt_d;
      out_chan_q  <= out_chan_d;
    end
  end

  assign evtValidOut   = (state_q == HAVE_EVT);
  assign evtTypeOut    = out_evt_q.evt_type;
  assign evtChanOut    = out_chan_q;
  assign evtRefNumOut  = out_evt_q.ref_num;
  assign evtLocateOut  = out_evt_q.locate;
  assign evtPriceOut   = out_evt_q.price;
  assign evtSharesOut  = out_evt_q.shares;
  assign evtBuySellOut = out_evt_q.buy_sell;
  assign dropCntOut    = drop_cnt_q;
  assign protoErrOut   = proto_err_q;

endmodule

// File: tb/tb_itch_event_arbiter.sv
// tb_itch_event_arbiter
//
// Directed bench for itch_event_arbiter. Stimulus tasks drive channel events
// and push the expected output events into a scoreboard queue; an independent
// monitor pops and compares whenever an output handshake is about to happen.

module tb_itch_event_arbiter;

  localparam int FIFO_DEPTH = 4;
  localparam int CNT_W      = 16;

  typedef struct packed {
    logic        chan;
    logic [1:0]  typ;
    logic [63:0] refNum;
    logic [15:0] loc;
    logic [31:0] px;
    logic [31:0] sh;
    logic        bs;
  } tbEvt_t;

  logic                  clkIn = 1'b0;
  logic                  rstNIn;
  logic [1:0]            chAddValidIn, chDelValidIn, chExecValidIn;
  logic [1:0][63:0]      chRefNumIn;
  logic [1:0][15:0]      chLocateIn;
  logic [1:0][31:0]      chPriceIn, chSharesIn;
  logic [1:0]            chBuySellIn;
  logic                  evtValidOut;
  logic                  evtReadyIn;
  logic [1:0]            evtTypeOut;
  logic                  evtChanOut;
  logic [63:0]           evtRefNumOut;
  logic [15:0]           evtLocateOut;
  logic [31:0]           evtPriceOut, evtSharesOut;
  logic                  evtBuySellOut;
  logic [1:0][CNT_W-1:0] dropCntOut;
  logic [1:0]            protoErrOut;

  int     testsRun    = 0;
  int     testsFailed = 0;
  int     cycleCnt    = 0;
  tbEvt_t sbQ[$];
  int     hsCycles[$];
  tbEvt_t expE;

  itch_event_arbiter #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
    .clkIn         (clkIn),
    .rstNIn        (rstNIn),
    .chAddValidIn  (chAddValidIn),
    .chDelValidIn  (chDelValidIn),
    .chExecValidIn (chExecValidIn),
    .chRefNumIn    (chRefNumIn),
    .chLocateIn    (chLocateIn),
    .chPriceIn     (chPriceIn),
    .chSharesIn    (chSharesIn),
    .chBuySellIn   (chBuySellIn),
    .evtValidOut   (evtValidOut),
    .evtReadyIn    (evtReadyIn),
    .evtTypeOut    (evtTypeOut),
    .evtChanOut    (evtChanOut),
    .evtRefNumOut  (evtRefNumOut),
    .evtLocateOut  (evtLocateOut),
    .evtPriceOut   (evtPriceOut),
    .evtSharesOut  (evtSharesOut),
    .evtBuySellOut (evtBuySellOut),
    .dropCntOut    (dropCntOut),
    .protoErrOut   (protoErrOut)
  );

  // Free-running 10-unit clock
  always #5 clkIn = ~clkIn;

  // Cycle counter used to check that a burst drains without bubbles
  always @(posedge clkIn) cycleCnt <= cycleCnt + 1;

  // One comparison: counts it, and reports a mismatch on a single line
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Advance one clock; inputs change 1 unit after the edge and valids are
  // pulses, so they are cleared here and re-driven by applyStimulus
  task automatic tick();
    @(posedge clkIn);
    #1;
    chAddValidIn  = '0;
    chDelValidIn  = '0;
    chExecValidIn = '0;
  endtask

  // Drive one channel's valids and fields for the coming clock edge
  task automatic applyStimulus(input int ch, input logic a, input logic d,
                               input logic x, input logic [63:0] r,
                               input logic [15:0] l, input logic [31:0] p,
                               input logic [31:0] s, input logic b);
    chAddValidIn[ch]  = a;
    chDelValidIn[ch]  = d;
    chExecValidIn[ch] = x;
    chRefNumIn[ch]    = r;
    chLocateIn[ch]    = l;
    chPriceIn[ch]     = p;
    chSharesIn[ch]    = s;
    chBuySellIn[ch]   = b;
  endtask

  // Queue the event the DUT is expected to present next
  task automatic expectEvt(input logic ch, input logic [1:0] t,
                           input logic [63:0] r, input logic [15:0] l,
                           input logic [31:0] p, input logic [31:0] s,
                           input logic b);
    tbEvt_t e;
    e.chan = ch; e.typ = t; e.refNum = r; e.loc = l; e.px = p; e.sh = s; e.bs = b;
    sbQ.push_back(e);
  endtask

  // Hold reset for two clocks and forget anything still expected
  task automatic doReset();
    rstNIn = 1'b0;
    sbQ.delete();
    tick();
    tick();
    rstNIn = 1'b1;
  endtask

  // Wait (bounded) until every expected event has been observed
  task automatic waitDrain(input int maxCycles);
    int n = 0;
    while (sbQ.size() != 0 && n < maxCycles) begin
      tick();
      n++;
    end
    checkOutput("drain_left", 64'(sbQ.size()), 64'd0);
    tick();
  endtask

  // Monitor: inputs are stable at the falling edge, so valid&ready here
  // means a handshake on the next rising edge; compare against the queue
  always @(negedge clkIn) begin
    if (rstNIn && evtValidOut && evtReadyIn) begin
      hsCycles.push_back(cycleCnt);
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_evt_valid", 64'(evtValidOut), 64'd0);
      end else begin
        expE = sbQ.pop_front();
        checkOutput("evt_chan",    64'(evtChanOut),    64'(expE.chan));
        checkOutput("evt_type",    64'(evtTypeOut),    64'(expE.typ));
        checkOutput("evt_ref",     evtRefNumOut,       expE.refNum);
        checkOutput("evt_locate",  64'(evtLocateOut),  64'(expE.loc));
        checkOutput("evt_price",   64'(evtPriceOut),   64'(expE.px));
        checkOutput("evt_shares",  64'(evtSharesOut),  64'(expE.sh));
        checkOutput("evt_buysell", 64'(evtBuySellOut), 64'(expE.bs));
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    chAddValidIn  = '0;
    chDelValidIn  = '0;
    chExecValidIn = '0;
    chRefNumIn    = '0;
    chLocateIn    = '0;
    chPriceIn     = '0;
    chSharesIn    = '0;
    chBuySellIn   = '0;
    evtReadyIn    = 1'b0;
    rstNIn        = 1'b1;
    #2 rstNIn     = 1'b0;
    #10;

    $display("[TB] reset state");
    checkOutput("rst_valid", 64'(evtValidOut), 64'd0);
    checkOutput("rst_type",  64'(evtTypeOut),  64'd0);
    checkOutput("rst_ref",   evtRefNumOut,     64'd0);
    checkOutput("rst_drop0", 64'(dropCntOut[0]), 64'd0);
    checkOutput("rst_drop1", 64'(dropCntOut[1]), 64'd0);
    checkOutput("rst_proto", 64'(protoErrOut),   64'd0);
    @(posedge clkIn);
    #1 rstNIn = 1'b1;

    $display("[TB] single ch0 add");
    evtReadyIn = 1'b1;
    applyStimulus(0, 1, 0, 0, 64'h11, 16'h0007, 32'd100, 32'd50, 1'b1);
    expectEvt(1'b0, 2'b01, 64'h11, 16'h0007, 32'd100, 32'd50, 1'b1);
    tick();
    checkOutput("t1_not_early", 64'(evtValidOut), 64'd0);
    tick();
    checkOutput("t1_valid", 64'(evtValidOut), 64'd1);
    waitDrain(10);

    $display("[TB] interleaved burst");
    doReset();
    evtReadyIn = 1'b1;
    hsCycles.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 64'h200 + 64'(i), 16'h20 + 16'(i),
                    32'd1000 + 32'(i), 32'd10 + 32'(i), 1'(i));
      applyStimulus(1, i == 2, i == 0, i == 1, 64'h300 + 64'(i), 16'h30 + 16'(i),
                    32'd2000 + 32'(i), 32'd20 + 32'(i), 1'(i + 1));
      expectEvt(1'b0, 2'b01, 64'h200 + 64'(i), 16'h20 + 16'(i),
                32'd1000 + 32'(i), 32'd10 + 32'(i), 1'(i));
      expectEvt(1'b1, (i == 0) ? 2'b10 : ((i == 1) ? 2'b11 : 2'b01),
                64'h300 + 64'(i), 16'h30 + 16'(i),
                32'd2000 + 32'(i), 32'd20 + 32'(i), 1'(i + 1));
      tick();
    end
    waitDrain(20);
    checkOutput("t2_hs_count", 64'(hsCycles.size()), 64'd6);
    if (hsCycles.size() == 6) begin
      checkOutput("t2_back_to_back", 64'(hsCycles[5] - hsCycles[0]), 64'd5);
    end

    $display("[TB] ch1 overflow under backpressure");
    doReset();
    evtReadyIn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 0, 0, 64'h100 + 64'(i), 16'h0042, 32'd500 + 32'(i),
                    32'd7, 1'b0);
      if (i < 5) begin
        expectEvt(1'b1, 2'b01, 64'h100 + 64'(i), 16'h0042, 32'd500 + 32'(i),
                  32'd7, 1'b0);
      end
      tick();
    end
    checkOutput("t3_drop1", 64'(dropCntOut[1]), 64'd1);
    checkOutput("t3_drop0", 64'(dropCntOut[0]), 64'd0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t3_hold_valid", 64'(evtValidOut), 64'd1);
      checkOutput("t3_hold_ref",   evtRefNumOut,     64'h100);
      checkOutput("t3_hold_chan",  64'(evtChanOut),  64'd1);
      tick();
    end
    evtReadyIn = 1'b1;
    waitDrain(20);
    checkOutput("t3_idle_after", 64'(evtValidOut), 64'd0);

    $display("[TB] push and pop on a full FIFO");
    doReset();
    evtReadyIn = 1'b0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 64'h400 + 64'(i), 16'h0009, 32'd900,
                    32'd100 + 32'(i), 1'b1);
      expectEvt(1'b0, 2'b10, 64'h400 + 64'(i), 16'h0009, 32'd900,
                32'd100 + 32'(i), 1'b1);
      tick();
    end
    evtReadyIn = 1'b1;
    applyStimulus(0, 0, 1, 0, 64'h405, 16'h0009, 32'd900, 32'd105, 1'b1);
    expectEvt(1'b0, 2'b10, 64'h405, 16'h0009, 32'd900, 32'd105, 1'b1);
    tick();
    checkOutput("t4_no_drop", 64'(dropCntOut[0]), 64'd0);
    evtReadyIn = 1'b0;
    applyStimulus(0, 0, 1, 0, 64'h406, 16'h0009, 32'd900, 32'd106, 1'b1);
    tick();
    checkOutput("t4_still_full_drop", 64'(dropCntOut[0]), 64'd1);
    evtReadyIn = 1'b1;
    waitDrain(20);

    $display("[TB] multi-hot valids");
    doReset();
    evtReadyIn = 1'b1;
    applyStimulus(0, 1, 0, 1, 64'h500, 16'h0005, 32'd55, 32'd5, 1'b0);
    applyStimulus(1, 0, 1, 1, 64'h501, 16'h0006, 32'd66, 32'd6, 1'b1);
    expectEvt(1'b0, 2'b01, 64'h500, 16'h0005, 32'd55, 32'd5, 1'b0);
    expectEvt(1'b1, 2'b10, 64'h501, 16'h0006, 32'd66, 32'd6, 1'b1);
    tick();
    checkOutput("t5_proto_set", 64'(protoErrOut), 64'h3);
    waitDrain(10);
    tick();
    checkOutput("t5_proto_sticky", 64'(protoErrOut), 64'h3);

    $display("[TB] reset mid-burst");
    evtReadyIn = 1'b0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 0, 64'h600 + 64'(i), 16'h0001, 32'd1, 32'd1, 1'b1);
      tick();
    end
    checkOutput("t6_drop_before", 64'(dropCntOut[0]), 64'd1);
    checkOutput("t6_valid_before", 64'(evtValidOut), 64'd1);
    #3;
    rstNIn = 1'b0;
    sbQ.delete();
    #1;
    checkOutput("t6_valid_async", 64'(evtValidOut), 64'd0);
    checkOutput("t6_drop_cleared", 64'(dropCntOut[0]), 64'd0);
    checkOutput("t6_proto_cleared", 64'(protoErrOut), 64'd0);
    @(posedge clkIn);
    #1 rstNIn = 1'b1;
    evtReadyIn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checkOutput("t6_fifo_empty", 64'(evtValidOut), 64'd0);
    end
    applyStimulus(0, 0, 0, 1, 64'h700, 16'h0002, 32'd70, 32'd7, 1'b0);
    applyStimulus(1, 0, 0, 1, 64'h701, 16'h0003, 32'd71, 32'd8, 1'b1);
    expectEvt(1'b0, 2'b11, 64'h700, 16'h0002, 32'd70, 32'd7, 1'b0);
    expectEvt(1'b1, 2'b11, 64'h701, 16'h0003, 32'd71, 32'd8, 1'b1);
    tick();
    waitDrain(10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
